// File: rtl/tug_game_pkg.sv
// Shared types and constants for the tug-of-war arithmetic game.
// The answer table must match the display's question table.
package tug_game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    PLAY      = 2'd2,
    WIN       = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  localparam logic [3:0] NUM_Q = 4'd10;

  function automatic logic [3:0] answer(input logic [3:0] q);
    case (q)
      4'd0:    answer = 4'd3;
      4'd1:    answer = 4'd7;
      4'd2:    answer = 4'd5;
      4'd3:    answer = 4'd9;
      4'd4:    answer = 4'd15;
      4'd5:    answer = 4'd8;
      4'd6:    answer = 4'd12;
      4'd7:    answer = 4'd7;
      4'd8:    answer = 4'd14;
      4'd9:    answer = 4'd15;
      default: answer = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/tug_player_entry.sv
// One player's keypad entry: value register, two-digit combine rule,
// wrong-answer lockout and correct/wrong decode of the submit key.
module tug_player_entry
  import tug_game_pkg::*;
#(
  parameter int PENALTY_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       clear,
  input  logic       digit_vld,
  input  logic [3:0] digit,
  input  logic       submit,
  input  logic [3:0] expected,
  output logic [3:0] val,
  output logic       correct_pulse,
  output logic       wrong_pulse
);

  localparam int LW = (PENALTY_CYC > 1) ? $clog2(PENALTY_CYC + 1) : 1;

  logic [3:0]    val_r, val_nx_s;
  logic [LW-1:0] lock_r, lock_nx_s;
  logic          live_s, sub_s;

  assign val = val_r;

  // Decode submit and compute the next value and lockout count.
  always_comb begin
    live_s        = enable && (lock_r == '0);
    sub_s         = live_s && submit;
    correct_pulse = sub_s && (val_r == expected);
    wrong_pulse   = sub_s && (val_r != expected);
    val_nx_s      = val_r;
    lock_nx_s     = lock_r;

    // A submit always clears the value, so a same-cycle digit is dropped.
    if (clear || wrong_pulse) begin
      val_nx_s = 4'd0;
    end else if (live_s && digit_vld && !submit && (digit <= 4'd9)) begin
      if ((val_r == 4'd1) && (digit <= 4'd5)) begin
        val_nx_s = 4'd10 + digit;
      end else begin
        val_nx_s = digit;
      end
    end else begin
      val_nx_s = val_r;
    end

    if (wrong_pulse) begin
      lock_nx_s = LW'(PENALTY_CYC);
    end else if (clear) begin
      lock_nx_s = '0;
    end else if (lock_r != '0) begin
      lock_nx_s = lock_r - LW'(1);
    end else begin
      lock_nx_s = lock_r;
    end
  end

  // Value and lockout registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      val_r  <= 4'd0;
      lock_r <= '0;
    end else begin
      val_r  <= val_nx_s;
      lock_r <= lock_nx_s;
    end
  end

endmodule

// File: rtl/tug_game_controller.sv
// Game-logic engine for the tug-of-war game: sequences IDLE, COUNTDOWN,
// PLAY and WIN and drives every display-side signal from registers.
module tug_game_controller
  import tug_game_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int ROPE_CENTER   = 320,
  parameter int ROPE_STEP     = 40,
  parameter int ROPE_P1_LIMIT = 160,
  parameter int ROPE_P2_LIMIT = 480,
  parameter int PENALTY_CYC   = 50_000_000,
  parameter int WIN_HOLD_S    = 5
) (
  input  logic       clk_100mhz,
  input  logic       reset_n,
  input  logic       start_pulse,
  input  logic       p1_digit_vld,
  input  logic [3:0] p1_digit,
  input  logic       p1_submit,
  input  logic       p2_digit_vld,
  input  logic [3:0] p2_digit,
  input  logic       p2_submit,
  output logic [3:0] q_id,
  output logic [3:0] p1_val,
  output logic [3:0] p2_val,
  output logic [9:0] rope_x,
  output logic [1:0] winner_code,
  output logic       is_idle,
  output logic       is_countdown,
  output logic [3:0] countdown_val
);

  localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int HW = (WIN_HOLD_S > 1) ? $clog2(WIN_HOLD_S + 1) : 1;
  localparam logic [9:0] CENTER = 10'(ROPE_CENTER);
  localparam logic [9:0] STEP   = 10'(ROPE_STEP);
  localparam logic [9:0] P1_LIM = 10'(ROPE_P1_LIMIT);
  localparam logic [9:0] P2_LIM = 10'(ROPE_P2_LIMIT);

  state_t        state_r, state_nx_s;
  logic [TW-1:0] cnt_r, cnt_nx_s;
  logic [HW-1:0] hold_r, hold_nx_s;
  logic [3:0]    cd_nx_s, q_nx_s;
  logic [9:0]    rope_nx_s;
  logic [1:0]    win_nx_s;
  logic          tick_s, at_limit_s, play_en_s, clear_s;
  logic          p1_ok_s, p1_bad_s, p2_ok_s, p2_bad_s;

  assign tick_s     = (cnt_r == TW'(CLK_HZ - 1));
  assign at_limit_s = (rope_x <= P1_LIM) || (rope_x >= P2_LIM);
  assign play_en_s  = (state_r == PLAY) && !at_limit_s;
  assign clear_s    = (state_r != PLAY) || p1_ok_s || p2_ok_s;

  tug_player_entry #(.PENALTY_CYC(PENALTY_CYC)) u_p1 (
    .clk(clk_100mhz), .reset_n(reset_n), .enable(play_en_s), .clear(clear_s),
    .digit_vld(p1_digit_vld), .digit(p1_digit), .submit(p1_submit),
    .expected(answer(q_id)), .val(p1_val),
    .correct_pulse(p1_ok_s), .wrong_pulse(p1_bad_s)
  );

  tug_player_entry #(.PENALTY_CYC(PENALTY_CYC)) u_p2 (
    .clk(clk_100mhz), .reset_n(reset_n), .enable(play_en_s), .clear(clear_s),
    .digit_vld(p2_digit_vld), .digit(p2_digit), .submit(p2_submit),
    .expected(answer(q_id)), .val(p2_val),
    .correct_pulse(p2_ok_s), .wrong_pulse(p2_bad_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nx_s = state_r;
    cd_nx_s    = countdown_val;
    q_nx_s     = q_id;
    rope_nx_s  = rope_x;
    win_nx_s   = winner_code;
    hold_nx_s  = hold_r;
    case (state_r)
      IDLE: begin
        if (start_pulse) begin
          state_nx_s = COUNTDOWN;
          cd_nx_s    = 4'd3;
        end else begin
          state_nx_s = IDLE;
        end
      end
      COUNTDOWN: begin
        if (tick_s && (countdown_val == 4'd1)) begin
          state_nx_s = PLAY;
          cd_nx_s    = 4'd0;
          q_nx_s     = 4'd0;
          rope_nx_s  = CENTER;
        end else if (tick_s) begin
          cd_nx_s = countdown_val - 4'd1;
        end else begin
          cd_nx_s = countdown_val;
        end
      end
      PLAY: begin
        // The win check sees the rope one cycle after it moved.
        if (rope_x <= P1_LIM) begin
          state_nx_s = WIN;
          win_nx_s   = WIN_P1;
          hold_nx_s  = '0;
        end else if (rope_x >= P2_LIM) begin
          state_nx_s = WIN;
          win_nx_s   = WIN_P2;
          hold_nx_s  = '0;
        end else if (p1_ok_s || p2_ok_s) begin
          q_nx_s = (q_id == NUM_Q - 4'd1) ? 4'd0 : q_id + 4'd1;
          if (p1_ok_s && !p2_ok_s) begin
            rope_nx_s = (rope_x <= P1_LIM + STEP) ? P1_LIM : rope_x - STEP;
          end else if (p2_ok_s && !p1_ok_s) begin
            rope_nx_s = (rope_x >= P2_LIM - STEP) ? P2_LIM : rope_x + STEP;
          end else begin
            rope_nx_s = rope_x;
          end
        end else begin
          state_nx_s = PLAY;
        end
      end
      WIN: begin
        if (start_pulse) begin
          state_nx_s = COUNTDOWN;
          cd_nx_s    = 4'd3;
          win_nx_s   = WIN_NONE;
        end else if (tick_s && (hold_r == HW'(WIN_HOLD_S - 1))) begin
          state_nx_s = IDLE;
          win_nx_s   = WIN_NONE;
          rope_nx_s  = CENTER;
        end else if (tick_s) begin
          hold_nx_s = hold_r + HW'(1);
        end else begin
          hold_nx_s = hold_r;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase

    if (state_nx_s != state_r) begin
      cnt_nx_s = '0;
    end else if (tick_s) begin
      cnt_nx_s = '0;
    end else begin
      cnt_nx_s = cnt_r + TW'(1);
    end
  end

  // State, timer and output registers.
  always_ff @(posedge clk_100mhz) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      hold_r        <= '0;
      q_id          <= 4'd0;
      rope_x        <= CENTER;
      winner_code   <= WIN_NONE;
      is_idle       <= 1'b1;
      is_countdown  <= 1'b0;
      countdown_val <= 4'd0;
    end else begin
      state_r       <= state_nx_s;
      cnt_r         <= cnt_nx_s;
      hold_r        <= hold_nx_s;
      q_id          <= q_nx_s;
      rope_x        <= rope_nx_s;
      winner_code   <= win_nx_s;
      is_idle       <= (state_nx_s == IDLE);
      is_countdown  <= (state_nx_s == COUNTDOWN);
      countdown_val <= cd_nx_s;
    end
  end

  logic unused_s;
  assign unused_s = p1_bad_s ^ p2_bad_s;

endmodule

// File: tb/tb_tug_game_controller.sv
// Directed bench for tug_game_controller with a fast 1 s tick (10 cycles)
// and an 8-cycle lockout.
module tb_tug_game_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_pulse = 1'b0;
  logic       p1_digit_vld = 1'b0, p1_submit = 1'b0;
  logic       p2_digit_vld = 1'b0, p2_submit = 1'b0;
  logic [3:0] p1_digit = 4'd0, p2_digit = 4'd0;
  logic [3:0] q_id, p1_val, p2_val, countdown_val;
  logic [9:0] rope_x;
  logic [1:0] winner_code;
  logic       is_idle, is_countdown;

  int checks = 0;
  int errors = 0;

  tug_game_controller #(
    .CLK_HZ(10), .ROPE_CENTER(320), .ROPE_STEP(40), .ROPE_P1_LIMIT(160),
    .ROPE_P2_LIMIT(480), .PENALTY_CYC(8), .WIN_HOLD_S(5)
  ) dut (
    .clk_100mhz(clk), .reset_n(reset_n), .start_pulse(start_pulse),
    .p1_digit_vld(p1_digit_vld), .p1_digit(p1_digit), .p1_submit(p1_submit),
    .p2_digit_vld(p2_digit_vld), .p2_digit(p2_digit), .p2_submit(p2_submit),
    .q_id(q_id), .p1_val(p1_val), .p2_val(p2_val), .rope_x(rope_x),
    .winner_code(winner_code), .is_idle(is_idle), .is_countdown(is_countdown),
    .countdown_val(countdown_val)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic p1_key(input logic [3:0] d);
    p1_digit = d; p1_digit_vld = 1'b1; step(); p1_digit_vld = 1'b0;
  endtask

  task automatic p2_key(input logic [3:0] d);
    p2_digit = d; p2_digit_vld = 1'b1; step(); p2_digit_vld = 1'b0;
  endtask

  task automatic p1_enter();
    p1_submit = 1'b1; step(); p1_submit = 1'b0;
  endtask

  task automatic p2_enter();
    p2_submit = 1'b1; step(); p2_submit = 1'b0;
  endtask

  task automatic both_enter();
    p1_submit = 1'b1; p2_submit = 1'b1; step();
    p1_submit = 1'b0; p2_submit = 1'b0;
  endtask

  task automatic both_answer(input logic [3:0] a, input logic [3:0] b, input bit two);
    p1_key(a); p2_key(a);
    if (two) begin p1_key(b); p2_key(b); end
    both_enter();
  endtask

  initial begin
    // 1: reset and countdown
    step(); step();
    check("rst_idle", is_idle, 1);
    check("rst_rope", rope_x, 320);
    check("rst_cd", countdown_val, 0);
    check("rst_win", winner_code, 0);
    reset_n = 1'b1;
    p1_key(4'd3);
    check("idle_key_ignored", p1_val, 0);
    start_pulse = 1'b1; step(); start_pulse = 1'b0;
    check("cd_active", is_countdown, 1);
    check("cd_3", countdown_val, 3);
    repeat (9) step();
    check("cd_3_hold", countdown_val, 3);
    step();
    check("cd_2", countdown_val, 2);
    repeat (10) step();
    check("cd_1", countdown_val, 1);
    repeat (9) step();
    check("cd_1_hold", is_countdown, 1);
    step();
    check("play_cd_off", is_countdown, 0);
    check("play_cd_val", countdown_val, 0);
    check("play_q", q_id, 0);
    check("play_rope", rope_x, 320);
    check("play_not_idle", is_idle, 0);

    // 2: walk to q_id 4 alternating players, then two-digit answer 15
    p1_key(4'd3);
    check("p1_digit3", p1_val, 3);
    p1_enter();
    check("q0_rope", rope_x, 280);
    check("q0_qid", q_id, 1);
    p2_key(4'd7); p2_enter();
    check("q1_rope", rope_x, 320);
    p1_key(4'd12);
    check("digit_over9_ignored", p1_val, 0);
    p1_key(4'd5); p1_enter();
    p2_key(4'd9); p2_enter();
    check("q4_reached", q_id, 4);
    check("q4_rope", rope_x, 320);
    p1_key(4'd1); p1_key(4'd5);
    check("p1_val15", p1_val, 15);
    p1_enter();
    check("q4_rope_after", rope_x, 280);
    check("q4_qid_after", q_id, 5);
    check("q4_p1_clr", p1_val, 0);
    check("q4_p2_clr", p2_val, 0);

    // 4: simultaneous correct answers, wrapping from q_id 9
    both_answer(4'd8, 4'd0, 1'b0);
    check("both_q5_rope", rope_x, 280);
    check("both_q5_qid", q_id, 6);
    both_answer(4'd1, 4'd2, 1'b1);
    both_answer(4'd7, 4'd0, 1'b0);
    both_answer(4'd1, 4'd4, 1'b1);
    check("q9_reached", q_id, 9);
    both_answer(4'd1, 4'd5, 1'b1);
    check("wrap_qid", q_id, 0);
    check("wrap_rope", rope_x, 280);
    check("wrap_p1_clr", p1_val, 0);

    // 3: wrong submit by P2 and its lockout
    p2_key(4'd4);
    check("p2_digit4", p2_val, 4);
    p2_enter();
    check("wrong_p2_clr", p2_val, 0);
    check("wrong_q_same", q_id, 0);
    check("wrong_rope_same", rope_x, 280);
    for (int i = 0; i < 8; i++) begin
      p2_key(4'd7);
      check($sformatf("lock_ignore_%0d", i), p2_val, 0);
    end
    p2_key(4'd7);
    check("lock_released", p2_val, 7);
    p2_key(4'd3); p2_enter();
    check("p2_back_center", rope_x, 320);
    check("p2_back_qid", q_id, 1);

    // 5: P1 wins with four correct answers
    p1_key(4'd7); p1_enter();
    p1_key(4'd5); p1_enter();
    p1_key(4'd9); p1_enter();
    check("pre_win_rope", rope_x, 200);
    p1_key(4'd1); p1_key(4'd5); p1_enter();
    check("win_rope", rope_x, 160);
    check("win_not_yet", winner_code, 0);
    step();
    check("win_p1", winner_code, 1);
    repeat (49) step();
    check("win_hold", winner_code, 1);
    check("win_hold_not_idle", is_idle, 0);
    step();
    check("win_to_idle", is_idle, 1);
    check("win_cleared", winner_code, 0);
    check("win_rope_center", rope_x, 320);

    // 6: reset during countdown at value 2
    start_pulse = 1'b1; step(); start_pulse = 1'b0;
    repeat (10) step();
    check("cd2_before_rst", countdown_val, 2);
    reset_n = 1'b0; step();
    check("mid_rst_idle", is_idle, 1);
    check("mid_rst_cd", countdown_val, 0);
    check("mid_rst_cd_flag", is_countdown, 0);
    check("mid_rst_rope", rope_x, 320);
    reset_n = 1'b1; step();
    check("post_rst_idle", is_idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tug_game_controller.md
Name: tug_game_controller

Overview:
- Game-logic engine that produces every display-side signal for the tug-of-war arithmetic game: question index, both players' entered answers, rope position, countdown, idle flag and winner.
- Consumes debounced single-cycle key pulses from the two player keypads and the start button.
- Sits between the input conditioning logic and Game_Display_Controller. It is the writer of that display interface.

Parameters:
- CLK_HZ, 100_000_000, clock cycles per second; drives the 1 s tick.
- ROPE_CENTER, 320, rope_x value at round start.
- ROPE_STEP, 40, rope_x change per correct answer.
- ROPE_P1_LIMIT, 160, rope_x at or below this value means P1 wins.
- ROPE_P2_LIMIT, 480, rope_x at or above this value means P2 wins.
- PENALTY_CYC, 50_000_000, lockout length in cycles after a wrong submit.
- WIN_HOLD_S, 5, seconds the WIN state is held before returning to IDLE.

Ports:
- clk_100mhz  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- start_pulse  in  1  start button, one-cycle pulse.
- p1_digit_vld  in  1  P1 digit key pulse.
- p1_digit  in  4  P1 digit, 0..9; values above 9 are ignored.
- p1_submit  in  1  P1 enter key pulse.
- p2_digit_vld  in  1  P2 digit key pulse.
- p2_digit  in  4  P2 digit, 0..9; values above 9 are ignored.
- p2_submit  in  1  P2 enter key pulse.
- q_id  out  4  current question, 0..9.
- p1_val  out  4  P1 entered value, 0..15.
- p2_val  out  4  P2 entered value, 0..15.
- rope_x  out  10  rope centre column.
- winner_code  out  2  0 none, 1 P1, 2 P2.
- is_idle  out  1  high in IDLE.
- is_countdown  out  1  high in COUNTDOWN.
- countdown_val  out  4  3, 2 or 1 during COUNTDOWN; 0 otherwise.

Behaviour:
- All outputs are registered. When reset_n is sampled low at a clock edge: state IDLE, q_id 0, p1_val 0, p2_val 0, rope_x ROPE_CENTER, winner_code 0, is_idle 1, is_countdown 0, countdown_val 0, tick counter 0, both lockouts cleared. Reset mid-game aborts at that edge with no residual state.
- 1 s tick: counter 0..CLK_HZ-1. It restarts at 0 on every state entry, and tick asserts when the count reaches CLK_HZ-1.
- State IDLE: start_pulse moves to COUNTDOWN with countdown_val 3. Key pulses are ignored.
- State COUNTDOWN: on each tick, countdown_val goes 3->2->1. On the tick while the value is 1, enter PLAY with countdown_val 0, q_id 0, both vals 0 and rope_x ROPE_CENTER. start_pulse and keys are ignored.
- State PLAY, digit entry per player (ignored while that player is locked out):
  - If the current value is 1 and the digit is 0..5, new value = 10 + digit.
  - Otherwise new value = digit.
- State PLAY, submit:
  - The value is compared with ANSWER[q_id]. The table is 3,7,5,9,15,8,12,7,14,15 for q_id 0..9.
  - A submit while locked out is ignored.
- Correct submit by one player only, same cycle:
  - P1: rope_x -= ROPE_STEP. P2: rope_x += ROPE_STEP.
  - q_id advances mod 10 (9 wraps to 0).
  - Both vals clear to 0 and both lockouts clear.
- Both correct in the same cycle: rope_x unchanged, q_id advances, both vals clear.
- Wrong submit: only that player's val clears. Their lockout loads PENALTY_CYC and counts down; digits and submits are ignored until it reaches 0.
- One correct and one wrong in the same cycle: the correct action applies and the wrong player's lockout is still loaded.
- Digit and submit from the same player in the same cycle: the submit wins and the digit is dropped.
- Win check, evaluated in the cycle after the rope update:
  - rope_x <= ROPE_P1_LIMIT: winner_code 1, enter WIN.
  - rope_x >= ROPE_P2_LIMIT: winner_code 2, enter WIN.
  - rope_x is never driven past a limit; the arithmetic saturates at the limit.
- State WIN: winner_code is held and inputs are ignored, except start_pulse, which restarts COUNTDOWN with winner_code 0. After WIN_HOLD_S ticks with no start, go to IDLE with winner_code 0 and rope_x ROPE_CENTER.
- Latency: every key pulse is reflected in the outputs exactly 1 cycle later. The winner appears 2 cycles after the deciding submit.

Decomposition:
- Shared package tug_game_pkg holds:
  - state enum IDLE/COUNTDOWN/PLAY/WIN;
  - winner code constants;
  - the ANSWER lookup function, which must stay consistent with the display's question table;
  - the NUM_Q=10 constant.
- One sub-module, tug_player_entry, instantiated twice. Each instance owns one player's value register, digit-combine rule, lockout counter and correct/wrong decode. It outputs val, correct_pulse and wrong_pulse.

Test Plan:
1. Reset with reset_n low for 2 cycles, then start_pulse (CLK_HZ=10) -> is_countdown high and countdown_val 3, 2, 1 at 10-cycle intervals, then PLAY with q_id 0 and rope_x 320.
2. In PLAY with q_id 4, P1 enters digits 1 then 5 and submits -> p1_val 15 before the submit; after it rope_x 280, q_id 5, p1_val 0, p2_val 0.
3. P2 submits 4 at q_id 0 -> p2_val 0, then P2 digits are ignored for PENALTY_CYC=8 cycles and accepted on the 9th.
4. Both players submit the correct value in the same cycle -> rope_x unchanged, q_id advances; starting at q_id 9 it wraps to 0.
5. P1 answers correctly 4 times from rope_x 320 -> rope_x 160 and winner_code 1 two cycles after the last submit; after WIN_HOLD_S ticks the block is in IDLE with is_idle 1.
6. reset_n low during COUNTDOWN at value 2 -> next cycle in IDLE, countdown_val 0, rope_x 320.
